// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants and the queue control bundle.
// Polarity constants here replace the old precompiled.v defines.
package if_id_queue_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic FLUSH_ON    = 1'b1;
  localparam logic STALL_ON    = 1'b1;

  // Per-cycle queue actions derived from the handshake inputs.
  typedef struct packed {
    logic push;
    logic pop;
  } ifq_ctrl_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch queue.
// Latency: write lands at the clock edge, read is combinational; no backpressure here.
// Data is deliberately not reset; occupancy tracking in the top masks stale entries.
module ifq_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, inst} pairs, presents them in order.
// Latency: 1 cycle push->id_valid; 0 cycles when IFQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: stall_o (registered-state decode) holds the PC when full; id_ready pops the head.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_ce,
  input  logic [INST_W-1:0] if_inst,
  output logic              stall_o,
  input  logic              flush,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] rd_ent;
  logic             empty;
  logic             full;
  logic             fetch_ok;
  ifq_ctrl_t        ctrl;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign stall_o  = full ? STALL_ON : ~STALL_ON;
  assign fetch_ok = (if_ce == CHIP_ENABLE) && (flush != FLUSH_ON);

`ifdef IFQ_BYPASS_EN
  logic byp;
  logic byp_take;

  // An empty queue forwards the live fetch; if decode takes it, nothing is stored.
  assign byp      = empty && fetch_ok;
  assign byp_take = byp && id_ready;
`endif

  always_comb begin
    ctrl      = '0;
`ifdef IFQ_BYPASS_EN
    ctrl.push = fetch_ok && !full && !byp_take;
`else
    ctrl.push = fetch_ok && !full;
`endif
    ctrl.pop  = !empty && id_ready && (flush != FLUSH_ON);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush == FLUSH_ON) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ctrl.push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (ctrl.pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({ctrl.push, ctrl.pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  ifq_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (ctrl.push),
    .waddr (wr_ptr),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  // Empty queue presents a zero pc and a NOP so decode never sees stale data.
  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    if (!empty) begin
      id_valid          = 1'b1;
      {id_pc, id_inst}  = rd_ent;
    end
`ifdef IFQ_BYPASS_EN
    else if (byp) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = if_inst;
    end
`endif
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table plus a scoreboard for streaming/wrap.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_ce;
  logic [31:0] if_inst;
  logic        stall_o;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_ce    (if_ce),
    .if_inst  (if_inst),
    .stall_o  (stall_o),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        est;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl[$];
  ent_t sbq[$];

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return 32'hC0DE_0000 | p;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic c,
                              input logic [31:0] p, input logic y, input logic k,
                              input logic v, input logic [31:0] ep, input logic s);
    vec_t t;
    t.rst   = r;
    t.flush = f;
    t.ce    = c;
    t.pc    = p;
    t.inst  = inst_of(p);
    t.rdy   = y;
    t.chk   = k;
    t.ev    = v;
    t.epc   = ep;
    t.einst = v ? inst_of(ep) : 32'h0;
    t.est   = s;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One scoreboard cycle: compare outputs against the model, then let the edge apply.
  task automatic run_cycle(input string nm, input logic c, input logic [31:0] p,
                           input logic [31:0] i, input logic y, output logic accepted);
    ent_t e;
    logic pop_now;
    rst = 1'b0; flush = 1'b0; if_ce = c; if_pc = p; if_inst = i; id_ready = y;
    @(negedge clk);
    chk({nm, " valid"}, {63'b0, id_valid}, {63'b0, sbq.size() != 0});
    chk({nm, " stall"}, {63'b0, stall_o}, {63'b0, sbq.size() == 4});
    if (sbq.size() != 0) begin
      chk({nm, " pc"},   {32'b0, id_pc},   {32'b0, sbq[0].pc});
      chk({nm, " inst"}, {32'b0, id_inst}, {32'b0, sbq[0].inst});
    end
    accepted = c && (sbq.size() < 4);
    pop_now  = y && (sbq.size() != 0);
    if (pop_now) void'(sbq.pop_front());
    if (accepted) begin
      e.pc = p; e.inst = i;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] pc;

    // reset with fetch enabled
    tbl.push_back(mk(1, 0, 1, 32'h100, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h100, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 32'h0, 0));
    // fill to full with decode stalled, fifth fetch held, then drain
    tbl.push_back(mk(0, 0, 1, 32'h0,  0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h4,  0, 1, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h8,  0, 1, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hC,  0, 1, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h10, 0, 1, 1, 32'h0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h10, 1, 1, 1, 32'h0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h10, 0, 1, 1, 32'h4, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h8, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 32'hC, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h10, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 32'h0, 0));
    // three entries, flush with a live fetch, then a fresh fetch
    tbl.push_back(mk(0, 0, 1, 32'h30, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h34, 0, 1, 1, 32'h30, 0));
    tbl.push_back(mk(0, 0, 1, 32'h38, 0, 1, 1, 32'h30, 0));
    tbl.push_back(mk(0, 1, 1, 32'h20, 1, 1, 1, 32'h30, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h40, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 32'h0, 0));
    // reset mid-operation, together with flush
    tbl.push_back(mk(0, 0, 1, 32'h50, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h54, 0, 1, 1, 32'h50, 0));
    tbl.push_back(mk(1, 1, 1, 32'h58, 1, 1, 1, 32'h50, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  0, 1, 0, 32'h0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; if_ce = tbl[i].ce;
      if_pc = tbl[i].pc; if_inst = tbl[i].inst; id_ready = tbl[i].rdy;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("row%0d valid", i), {63'b0, id_valid}, {63'b0, tbl[i].ev});
        chk($sformatf("row%0d stall", i), {63'b0, stall_o},  {63'b0, tbl[i].est});
        chk($sformatf("row%0d pc", i),    {32'b0, id_pc},    {32'b0, tbl[i].epc});
        chk($sformatf("row%0d inst", i),  {32'b0, id_inst},  {32'b0, tbl[i].einst});
      end
      @(posedge clk);
      #1;
    end

    // stream with decode always ready
    for (int i = 0; i < 4; i++) begin
      run_cycle($sformatf("stream%0d", i), 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, acc);
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle($sformatf("stream_tail%0d", i), 1'b0, 32'h0, 32'h0, 1'b1, acc);
    end

    // continuous fetch against a toggling decode; PC holds whenever the fetch is refused
    pc = 32'h200;
    for (int i = 0; i < 20; i++) begin
      run_cycle($sformatf("wrap%0d", i), 1'b1, pc, inst_of(pc), 1'(i % 2), acc);
      if (acc) pc = pc + 32'h4;
    end
    for (int i = 0; i < 8; i++) begin
      run_cycle($sformatf("drain%0d", i), 1'b0, 32'h0, 32'h0, 1'b1, acc);
    end
    chk("drain empty", 64'(sbq.size()), 64'd0);

`ifdef IFQ_BYPASS_EN
    rst = 1'b0; flush = 1'b0; if_ce = 1'b1; if_pc = 32'h8; if_inst = 32'h1234; id_ready = 1'b1;
    @(negedge clk);
    chk("bypass valid", {63'b0, id_valid}, 64'd1);
    chk("bypass pc",    {32'b0, id_pc},    64'h8);
    chk("bypass inst",  {32'b0, id_inst},  64'h1234);
    @(posedge clk);
    #1;
    if_ce = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("bypass consumed", {63'b0, id_valid}, 64'd0);
    @(posedge clk);
    #1;
`else
    run_cycle("lat0", 1'b1, 32'h8, 32'h1234, 1'b1, acc);
    run_cycle("lat1", 1'b0, 32'h0, 32'h0, 1'b1, acc);
    run_cycle("lat2", 1'b0, 32'h0, 32'h0, 1'b0, acc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
